ddr_req_arbiter: RTL
====================

DDR_REQ_ARBITER -- requirements
Module: ddr_req_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 25, word address width.
REQ-002 SHALL have parameter DATA_W, default 256, data width (byte-enable width DATA_W/8).
REQ-003 SHALL have parameter TIMEOUT, default 1023, maximum WAIT cycles before abort.
REQ-004 SHALL have port clk, in, 1, single clock for all logic.
REQ-005 SHALL have port reset, in, 1, asynchronous, active-high.
REQ-006 SHALL have port p_wr, in, 2, per-requester write request, level, held until p_done.
REQ-007 SHALL have port p_rd, in, 2, per-requester read request, level, held until p_done.
REQ-008 SHALL have port p_adr, in, 2*ADDR_W, per-requester address; port i at [i*ADDR_W +: ADDR_W].
REQ-009 SHALL have port p_wdata, in, 2*DATA_W, per-requester write data.
REQ-010 SHALL have port p_be, in, 2*DATA_W/8, per-requester byte enables.
REQ-011 SHALL have port p_grant, out, 2, one-hot owner of the transaction in flight.
REQ-012 SHALL have port p_done, out, 2, one-cycle completion pulse to owner.
REQ-013 SHALL have port p_rvalid, out, 2, one-cycle read-data-valid pulse to owner.
REQ-014 SHALL have port p_rdata, out, DATA_W, registered read data, shared by both requesters.
REQ-015 SHALL have ports wr_rq, rd_rq (out, 1), wr_adr, rd_adr (out, ADDR_W), wr_data (out, DATA_W), byte_enable (out, DATA_W/8): DDR control side.
REQ-016 SHALL have ports rd_valid (in, 1), rd_data (in, DATA_W), action_done (in, 1): DDR control side completion.
REQ-017 SHALL have ports busy (out, 1, state != IDLE) and err_timeout (out, 1, sticky timeout flag).

Function
REQ-018 SHALL implement states IDLE, ISSUE, WAIT; one transaction outstanding at a time.
REQ-019 In IDLE, port i is requesting when p_wr[i]|p_rd[i]; if none, SHALL remain IDLE.
REQ-020 Single requester SHALL be granted; both requesting SHALL grant the port not served last (round-robin pointer last_grant).
REQ-021 Port asserting p_wr and p_rd together SHALL be served as write; read stays pending for a later grant.
REQ-022 On grant edge SHALL latch address, data, byte enables, op type, set p_grant, enter ISSUE; all outputs registered.
REQ-023 In ISSUE SHALL assert exactly one of wr_rq/rd_rq for exactly one cycle, with wr_adr or rd_adr, wr_data, byte_enable from latch; then enter WAIT. Latency request-visible to wr_rq/rd_rq = 1 cycle.
REQ-024 wr_adr/rd_adr/wr_data/byte_enable SHALL hold latched values through WAIT.
REQ-025 On rd_valid during ISSUE or WAIT of a read SHALL capture rd_data into p_rdata and pulse p_rvalid[owner] next cycle; rd_valid in IDLE or during a write SHALL be ignored.
REQ-026 On action_done in ISSUE or WAIT SHALL pulse p_done[owner] next cycle, clear p_grant, update last_grant to owner, return to IDLE; rd_valid and action_done in same cycle SHALL produce p_rvalid and p_done in same cycle.
REQ-027 Earliest next grant SHALL be one cycle after p_done (IDLE always visited once).
REQ-028 WAIT counter (width clog2(TIMEOUT+1)) SHALL clear on ISSUE entry, increment per WAIT cycle; on reaching TIMEOUT without action_done SHALL pulse p_done[owner], set err_timeout, return to IDLE.
REQ-029 err_timeout SHALL remain set until reset; arbitration SHALL continue normally after timeout.
REQ-030 Requests withdrawn before grant SHALL be lost silently; requester SHALL NOT drop a request after grant (undefined otherwise).

Reset
REQ-031 While reset high: state IDLE, all outputs 0 (p_rdata 0), counter 0, last_grant = 1 so port 0 wins first contention.
REQ-032 Reset mid-transaction SHALL abandon it with no p_done or p_rvalid pulse.

Verification
REQ-033 Port 0 write adr 0x10, data 0xA5.., be all-ones -> wr_rq one cycle, wr_adr 0x10, action_done after 5 cycles -> p_done[0] pulse, busy low next cycle.
REQ-034 Both ports read after reset -> port 0 served first, then port 1; repeat -> port 0 last served... port 1 not starved, alternation 0,1,0,1.
REQ-035 Port 1 read, rd_valid with data 0x1234 same cycle as action_done -> p_rvalid[1] and p_done[1] same cycle, p_rdata = 0x1234.
REQ-036 No action_done with TIMEOUT=15 -> p_done pulse 15 WAIT cycles after ISSUE, err_timeout = 1, next request still served.
REQ-037 Reset asserted during WAIT -> all outputs 0 immediately, no p_done; first post-reset contention granted to port 0.

Source files
------------

// File: rtl/ddr_req_arbiter.sv
// Two-port arbiter in front of a single DDR controller command port.
// One transaction is outstanding at a time. Contention is resolved round-robin.
// A transaction that never sees action_done is aborted after TIMEOUT wait cycles.
module ddr_req_arbiter #(
    parameter int ADDR_W  = 25,
    parameter int DATA_W  = 256,
    parameter int TIMEOUT = 1023
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [1:0]               p_wr,
    input  logic [1:0]               p_rd,
    input  logic [2*ADDR_W-1:0]      p_adr,
    input  logic [2*DATA_W-1:0]      p_wdata,
    input  logic [2*DATA_W/8-1:0]    p_be,
    output logic [1:0]               p_grant,
    output logic [1:0]               p_done,
    output logic [1:0]               p_rvalid,
    output logic [DATA_W-1:0]        p_rdata,
    output logic                     wr_rq,
    output logic                     rd_rq,
    output logic [ADDR_W-1:0]        wr_adr,
    output logic [ADDR_W-1:0]        rd_adr,
    output logic [DATA_W-1:0]        wr_data,
    output logic [DATA_W/8-1:0]      byte_enable,
    input  logic                     rd_valid,
    input  logic [DATA_W-1:0]        rd_data,
    input  logic                     action_done,
    output logic                     busy,
    output logic                     err_timeout
);
    localparam int BE_W  = DATA_W / 8;
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t               state_reg, state_next;
    logic [1:0]           grant_reg, grant_next;
    logic [1:0]           done_reg, done_next;
    logic [1:0]           rvalid_reg, rvalid_next;
    logic [DATA_W-1:0]    rdata_reg, rdata_next;
    logic                 wr_rq_reg, wr_rq_next;
    logic                 rd_rq_reg, rd_rq_next;
    logic [ADDR_W-1:0]    wr_adr_reg, wr_adr_next;
    logic [ADDR_W-1:0]    rd_adr_reg, rd_adr_next;
    logic [DATA_W-1:0]    wdata_reg, wdata_next;
    logic [BE_W-1:0]      be_reg, be_next;
    logic                 is_write_reg, is_write_next;
    logic                 last_grant_reg, last_grant_next;
    logic [CNT_W-1:0]     cnt_reg, cnt_next;
    logic                 err_reg, err_next;

    // Per-port views of the packed request buses
    logic [1:0]           req;
    logic [ADDR_W-1:0]    adr_arr   [2];
    logic [DATA_W-1:0]    wdata_arr [2];
    logic [BE_W-1:0]      be_arr    [2];
    logic                 sel;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_port
            assign req[gi]       = p_wr[gi] | p_rd[gi];
            assign adr_arr[gi]   = p_adr[gi*ADDR_W +: ADDR_W];
            assign wdata_arr[gi] = p_wdata[gi*DATA_W +: DATA_W];
            assign be_arr[gi]    = p_be[gi*BE_W +: BE_W];
        end
    endgenerate

    // Winner index: the sole requester, or the port not served last
    assign sel = (req == 2'b11) ? ~last_grant_reg : req[1];

    // State and output registers; reset abandons any transaction silently
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg      <= IDLE;
            grant_reg      <= '0;
            done_reg       <= '0;
            rvalid_reg     <= '0;
            rdata_reg      <= '0;
            wr_rq_reg      <= 1'b0;
            rd_rq_reg      <= 1'b0;
            wr_adr_reg     <= '0;
            rd_adr_reg     <= '0;
            wdata_reg      <= '0;
            be_reg         <= '0;
            is_write_reg   <= 1'b0;
            last_grant_reg <= 1'b1;
            cnt_reg        <= '0;
            err_reg        <= 1'b0;
        end else begin
            state_reg      <= state_next;
            grant_reg      <= grant_next;
            done_reg       <= done_next;
            rvalid_reg     <= rvalid_next;
            rdata_reg      <= rdata_next;
            wr_rq_reg      <= wr_rq_next;
            rd_rq_reg      <= rd_rq_next;
            wr_adr_reg     <= wr_adr_next;
            rd_adr_reg     <= rd_adr_next;
            wdata_reg      <= wdata_next;
            be_reg         <= be_next;
            is_write_reg   <= is_write_next;
            last_grant_reg <= last_grant_next;
            cnt_reg        <= cnt_next;
            err_reg        <= err_next;
        end
    end

    // Next-state logic: grant in IDLE, one-cycle command in ISSUE, completion/timeout in ISSUE/WAIT
    always_comb begin
        state_next      = state_reg;
        grant_next      = grant_reg;
        done_next       = 2'b00;
        rvalid_next     = 2'b00;
        rdata_next      = rdata_reg;
        wr_rq_next      = 1'b0;
        rd_rq_next      = 1'b0;
        wr_adr_next     = wr_adr_reg;
        rd_adr_next     = rd_adr_reg;
        wdata_next      = wdata_reg;
        be_next         = be_reg;
        is_write_next   = is_write_reg;
        last_grant_next = last_grant_reg;
        cnt_next        = cnt_reg;
        err_next        = err_reg;

        case (state_reg)
            IDLE: begin
                if (|req) begin
                    state_next    = ISSUE;
                    grant_next    = sel ? 2'b10 : 2'b01;
                    // A port raising both lines is served as a write first
                    is_write_next = p_wr[sel];
                    wdata_next    = wdata_arr[sel];
                    be_next       = be_arr[sel];
                    cnt_next      = '0;
                    if (p_wr[sel]) begin
                        wr_adr_next = adr_arr[sel];
                        wr_rq_next  = 1'b1;
                    end else begin
                        rd_adr_next = adr_arr[sel];
                        rd_rq_next  = 1'b1;
                    end
                end
            end
            ISSUE, WAIT: begin
                if (rd_valid && !is_write_reg) begin
                    rdata_next  = rd_data;
                    rvalid_next = grant_reg;
                end
                if (state_reg == WAIT) begin
                    cnt_next = cnt_reg + 1'b1;
                end
                if (action_done) begin
                    state_next      = IDLE;
                    done_next       = grant_reg;
                    grant_next      = 2'b00;
                    last_grant_next = grant_reg[1];
                end else if (state_reg == WAIT && cnt_reg == CNT_W'(TIMEOUT - 1)) begin
                    state_next      = IDLE;
                    done_next       = grant_reg;
                    grant_next      = 2'b00;
                    last_grant_next = grant_reg[1];
                    err_next        = 1'b1;
                end else begin
                    state_next = WAIT;
                end
            end
            default: begin
                state_next = IDLE;
                grant_next = 2'b00;
            end
        endcase
    end

    assign p_grant     = grant_reg;
    assign p_done      = done_reg;
    assign p_rvalid    = rvalid_reg;
    assign p_rdata     = rdata_reg;
    assign wr_rq       = wr_rq_reg;
    assign rd_rq       = rd_rq_reg;
    assign wr_adr      = wr_adr_reg;
    assign rd_adr      = rd_adr_reg;
    assign wr_data     = wdata_reg;
    assign byte_enable = be_reg;
    assign busy        = (state_reg != IDLE);
    assign err_timeout = err_reg;

endmodule
